output_csc_v2: RTL and testbench
================================

Name: output_csc_v2

Overview:
- Parametrised successor to the fixed RGB->YPbPr709 output colour-space converter in the output path, between the scaler output and the video transmitter.
- Applies a runtime-programmable 3x3 matrix plus per-channel offsets, with configurable input and output widths.
- Coefficient writes are double-buffered and take effect only at frame start.
- Latency is constant whether conversion is enabled or bypassed, so toggling the mode never shifts sync timing.

Parameters:
- DW_IN, 8, input component width.
- DW_OUT, 8, output component width.
- COEFF_W, 18, signed coefficient width (two's complement).
- FRAC_W, 14, fractional bits of coefficients; 1.0 = 2^FRAC_W.
- OFFS_W, 11, signed offset width, in DW_OUT LSB units.
- VS_POL, 1, VSYNC active level.

Ports:
- PCLK_i  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  request conversion (1) or bypass (0); sampled at frame start
- R_i / G_i / B_i  in  DW_IN each  input components
- HSYNC_i / VSYNC_i / DE_i  in  1 each  input syncs and data enable
- coeff_we  in  1  shadow register write strobe
- coeff_addr  in  4  0-8 matrix (row-major: out0 R,G,B; out1 R,G,B; out2 R,G,B); 9-11 offsets out0..out2
- coeff_wdata  in  COEFF_W  write data; offsets use the low OFFS_W bits
- commit_pending_o  out  1  shadow written but not yet committed
- R_o / G_o / B_o  out  DW_OUT each  out0 / out1 / out2
- HSYNC_o / VSYNC_o / DE_o  out  1 each  delayed syncs and data enable

Behaviour:
- Reset (synchronous, active-high). All outputs go to 0 and commit_pending_o to 0. Active and shadow matrices load identity: diagonal 2^FRAC_W, others 0, offsets 0. Active enable goes to 0. Pipeline syncs clear to 0.
- Shadow writes:
  - coeff_we writes the shadow register at coeff_addr and sets commit_pending_o.
  - coeff_addr 12-15: write ignored, pending flag unaffected.
- Frame start: the cycle where VSYNC_i changes from inactive to active level (VS_POL), detected with one registered copy of VSYNC_i.
  - At frame start, active registers <= shadow, active enable <= enable, commit_pending_o <= 0.
  - Simultaneous coeff_we at frame start: the write lands in shadow only, and commit_pending_o stays 1.
- Datapath, fixed LATENCY = 6 cycles from input to output in both modes:
  - c1-c2: 9 products, signed coeff x zero-extended input. Full precision DW_IN+COEFF_W+1 bits.
  - c3: registered products.
  - c4: acc = sum of 3 products + (offset << SH) + (1 << (SH-1)), where SH = FRAC_W + DW_IN - DW_OUT. Widths are grown by 2 bits so the sum cannot overflow.
  - c5: res = acc >>> SH (arithmetic shift); clamp to [0, 2^DW_OUT-1].
  - c6: output register.
  - DE low at c6: output component = clamp(offset) rather than the computed value (e.g. Pb/Pr = 128, Y = 0 for YPbPr offsets).
- Bypass (active enable = 0): inputs delayed 6 cycles.
  - If DW_OUT > DW_IN: left-justify, then replicate MSBs into the LSBs.
  - If DW_OUT < DW_IN: truncate.
- Syncs/DE are delayed exactly 6 cycles in both modes.
- Mode changes mid-frame have no effect until the next frame start.
- Constraints: SH >= 1 is required. Synthesis-time $error if FRAC_W + DW_IN <= DW_OUT.

Optional Feature:
- Macro OUTPUT_CSC_V2_DITHER_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,15,13,4; seed 16'hACE1 on reset) advances every cycle DE_i is high.
  - The top SH bits of the LFSR replace the constant rounding term (1 << (SH-1)) in c4.
  - Bypass is unaffected, and latency is unchanged.
- Undefined: constant round-half-up as specified above; no LFSR logic is present.

Test Plan:
- Identity after reset, enable=1, R/G/B = 10/20/30 with DE=1 -> R_o/G_o/B_o = 10/20/30 exactly 6 cycles later; HSYNC/VSYNC/DE aligned.
- Load BT.709 via shadow: row0 3483/11718/1183, row1 -1877/-6315/8192, row2 8192/-7441/-751, offsets 0/128/128.
  - Commit at frame start, then feed white 255/255/255 -> Y=255, Pb=128, Pr=128.
  - Feed black -> 0/128/128.
- Write shadow mid-frame -> outputs keep the old matrix and commit_pending_o=1 until the VSYNC edge; the new values apply from the first pixel after the edge and commit_pending_o=0.
- Clamp: coeff[0] = 32768 (2.0), R_i = 200 -> R_o = 255. Coeff[0] = -16384, R_i = 50 -> R_o = 0.
- Toggle enable mid-frame -> no output change until the next frame start. Latency stays 6 in both modes with no sync glitch.
- Assert reset mid-frame with a pending commit -> next cycle all outputs are 0, commit_pending_o=0 and the identity matrix is active; DE=0 blank output = 0 offsets.

Source files
------------

// File: rtl/output_csc_v2.sv
// Programmable 3x3 colour-space converter with per-channel offsets and a fixed 6-cycle latency.
// Define OUTPUT_CSC_V2_DITHER_EN to replace the constant rounding term with LFSR dither.
module output_csc_v2 #(
  parameter int DW_IN   = 8,
  parameter int DW_OUT  = 8,
  parameter int COEFF_W = 18,
  parameter int FRAC_W  = 14,
  parameter int OFFS_W  = 11,
  parameter bit VS_POL  = 1'b1
) (
  input  logic               PCLK_i,
  input  logic               reset,
  input  logic               enable,
  input  logic [DW_IN-1:0]   R_i,
  input  logic [DW_IN-1:0]   G_i,
  input  logic [DW_IN-1:0]   B_i,
  input  logic               HSYNC_i,
  input  logic               VSYNC_i,
  input  logic               DE_i,
  input  logic               coeff_we,
  input  logic [3:0]         coeff_addr,
  input  logic [COEFF_W-1:0] coeff_wdata,
  output logic               commit_pending_o,
  output logic [DW_OUT-1:0]  R_o,
  output logic [DW_OUT-1:0]  G_o,
  output logic [DW_OUT-1:0]  B_o,
  output logic               HSYNC_o,
  output logic               VSYNC_o,
  output logic               DE_o
);
  localparam int SH   = FRAC_W + DW_IN - DW_OUT;
  localparam int PW   = DW_IN + COEFF_W + 1;
  localparam int AW   = ((PW > OFFS_W + SH) ? PW : OFFS_W + SH) + 2;
  localparam int RW   = AW - SH;
  localparam int PIXW = 3 * DW_IN;
  localparam logic signed [COEFF_W-1:0] UNITY = COEFF_W'(1 << FRAC_W);

  generate
    if (FRAC_W + DW_IN <= DW_OUT) begin : g_bad_shift
      $error("output_csc_v2: FRAC_W + DW_IN must exceed DW_OUT");
    end
  endgenerate

  logic signed [COEFF_W-1:0] coef_sh_q  [9];
  logic signed [COEFF_W-1:0] coef_act_q [9];
  logic signed [OFFS_W-1:0]  offs_sh_q  [3];
  logic signed [OFFS_W-1:0]  offs_act_q [3];
  logic en_act_q, vs_q, pend_q, pend_d;
  logic frame_start, wr_coef, wr_offs;
  logic [1:0] offs_idx;

  assign frame_start = (VSYNC_i == VS_POL) && (vs_q != VS_POL);
  assign wr_coef     = coeff_we && (coeff_addr < 4'd9);
  assign wr_offs     = coeff_we && (coeff_addr >= 4'd9) && (coeff_addr < 4'd12);
  assign offs_idx    = 2'(coeff_addr - 4'd9);
  // A write coinciding with frame start lands in shadow only, so it stays pending.
  assign pend_d      = (wr_coef || wr_offs) ? 1'b1 : (frame_start ? 1'b0 : pend_q);

  always_ff @(posedge PCLK_i) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        coef_sh_q[i]  <= (i % 4 == 0) ? UNITY : '0;
        coef_act_q[i] <= (i % 4 == 0) ? UNITY : '0;
      end
      for (int i = 0; i < 3; i++) begin
        offs_sh_q[i]  <= '0;
        offs_act_q[i] <= '0;
      end
      en_act_q <= 1'b0;
      pend_q   <= 1'b0;
      vs_q     <= ~VS_POL;
    end else begin
      vs_q   <= VSYNC_i;
      pend_q <= pend_d;
      if (frame_start) begin
        coef_act_q <= coef_sh_q;
        offs_act_q <= offs_sh_q;
        en_act_q   <= enable;
      end
      if (wr_coef) coef_sh_q[coeff_addr] <= coeff_wdata;
      if (wr_offs) offs_sh_q[offs_idx]   <= coeff_wdata[OFFS_W-1:0];
    end
  end

  function automatic logic [DW_IN-1:0] comp(input logic [PIXW-1:0] p, input int c);
    return p[(2-c)*DW_IN +: DW_IN];
  endfunction

  function automatic logic signed [PW-1:0] mul(input logic signed [COEFF_W-1:0] c,
                                               input logic [DW_IN-1:0] x);
    logic signed [PW-1:0] a, b;
    a = PW'(c);
    b = PW'({1'b0, x});
    return a * b;
  endfunction

  function automatic logic [DW_OUT-1:0] clamp(input logic signed [RW-1:0] v);
    logic signed [RW-1:0] top;
    top = RW'({1'b0, {DW_OUT{1'b1}}});
    if (v[RW-1]) return '0;
    if (v > top) return '1;
    return v[DW_OUT-1:0];
  endfunction

  // Width change for bypass: MSB-justify, repeating the input MSBs into any extra LSBs.
  function automatic logic [DW_OUT-1:0] conv(input logic [DW_IN-1:0] x);
    logic [DW_OUT-1:0] y;
    for (int i = 0; i < DW_OUT; i++) y[DW_OUT-1-i] = x[DW_IN-1-(i % DW_IN)];
    return y;
  endfunction

  logic [PIXW-1:0]      pix_q  [1:5];
  logic [2:0]           sync_q [1:5];
  logic [5:1]           en_q;
  logic signed [PW-1:0] prod_d [9];
  logic signed [PW-1:0] prod2_q [9];
  logic signed [PW-1:0] prod3_q [9];
  logic signed [AW-1:0] acc_d [3];
  logic signed [AW-1:0] acc4_q [3];
  logic signed [AW-1:0] rnd;
  logic [DW_OUT-1:0]    res_d [3];
  logic [DW_OUT-1:0]    res5_q [3];
  logic [DW_OUT-1:0]    out_d [3];
  logic [DW_OUT-1:0]    out_q [3];
  logic                 hs_q, vso_q, de_q;

`ifdef OUTPUT_CSC_V2_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hD008 : 16'h0000);

  always_ff @(posedge PCLK_i) begin
    if (reset)     lfsr_q <= 16'hACE1;
    else if (DE_i) lfsr_q <= lfsr_d;
  end

  generate
    if (SH <= 16) begin : g_rnd_narrow
      assign rnd = AW'(lfsr_q[15 -: SH]);
    end else begin : g_rnd_wide
      assign rnd = AW'({lfsr_q, {(SH-16){1'b0}}});
    end
  endgenerate
`else
  assign rnd = AW'(1) << (SH - 1);
`endif

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        prod_d[r*3+c] = mul(coef_act_q[r*3+c], comp(pix_q[1], c));
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      acc_d[r] = AW'(prod3_q[r*3]) + AW'(prod3_q[r*3+1]) + AW'(prod3_q[r*3+2])
               + (AW'(offs_act_q[r]) <<< SH) + rnd;
      res_d[r] = clamp(RW'(acc4_q[r] >>> SH));
      out_d[r] = en_q[5] ? (sync_q[5][0] ? res5_q[r] : clamp(RW'(offs_act_q[r])))
                         : conv(comp(pix_q[5], r));
    end
  end

  always_ff @(posedge PCLK_i) begin
    if (reset) begin
      for (int s = 1; s <= 5; s++) begin
        pix_q[s]  <= '0;
        sync_q[s] <= '0;
      end
      en_q <= '0;
      for (int i = 0; i < 9; i++) begin
        prod2_q[i] <= '0;
        prod3_q[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        acc4_q[i] <= '0;
        res5_q[i] <= '0;
        out_q[i]  <= '0;
      end
      {hs_q, vso_q, de_q} <= 3'b000;
    end else begin
      pix_q[1]  <= {R_i, G_i, B_i};
      sync_q[1] <= {HSYNC_i, VSYNC_i, DE_i};
      en_q[1]   <= frame_start ? enable : en_act_q;
      for (int s = 2; s <= 5; s++) begin
        pix_q[s]  <= pix_q[s-1];
        sync_q[s] <= sync_q[s-1];
        en_q[s]   <= en_q[s-1];
      end
      prod2_q <= prod_d;
      prod3_q <= prod2_q;
      acc4_q  <= acc_d;
      res5_q  <= res_d;
      out_q   <= out_d;
      {hs_q, vso_q, de_q} <= sync_q[5];
    end
  end

  assign commit_pending_o = pend_q;
  assign R_o     = out_q[0];
  assign G_o     = out_q[1];
  assign B_o     = out_q[2];
  assign HSYNC_o = hs_q;
  assign VSYNC_o = vso_q;
  assign DE_o    = de_q;
endmodule

// File: tb/tb_output_csc_v2.sv
// Self-checking bench for output_csc_v2: hand-computed vectors plus a per-cycle arithmetic reference model.
module tb_output_csc_v2;
  logic        PCLK_i = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  R_i = '0, G_i = '0, B_i = '0;
  logic        HSYNC_i = 1'b0, VSYNC_i = 1'b0, DE_i = 1'b0;
  logic        coeff_we = 1'b0;
  logic [3:0]  coeff_addr = '0;
  logic [17:0] coeff_wdata = '0;
  logic        commit_pending_o;
  logic [7:0]  R_o, G_o, B_o;
  logic        HSYNC_o, VSYNC_o, DE_o;

  output_csc_v2 dut (
    .PCLK_i(PCLK_i), .reset(reset), .enable(enable),
    .R_i(R_i), .G_i(G_i), .B_i(B_i),
    .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
    .commit_pending_o(commit_pending_o),
    .R_o(R_o), .G_o(G_o), .B_o(B_o),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o)
  );

  always #5 PCLK_i = ~PCLK_i;

  typedef struct { int r, g, b, hs, vs, de; } exp_t;
  typedef struct { int r, g, b, er, eg, eb; } vec_t;

  exp_t exp_q[$];
  int   m_sh[12], m_act[12];
  bit   m_en, m_pend, m_vs;
  int   dc_left = 0;
  int   checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int cl(input longint v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  function automatic void model_reset();
    exp_t z;
    z = '{default: 0};
    for (int i = 0; i < 12; i++) m_sh[i] = (i == 0 || i == 4 || i == 8) ? 16384 : 0;
    m_act = m_sh;
    m_en = 0; m_pend = 0; m_vs = 0; dc_left = 0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(z);
  endfunction

  // Output that the spec's arithmetic yields for the pixel currently on the inputs.
  function automatic exp_t expect_now();
    exp_t e;
    int px[3];
    int y;
    longint acc;
    px[0] = R_i; px[1] = G_i; px[2] = B_i;
    e.hs = HSYNC_i; e.vs = VSYNC_i; e.de = DE_i;
    e.r = 0; e.g = 0; e.b = 0;
    for (int ch = 0; ch < 3; ch++) begin
      if (!m_en) y = px[ch];
      else if (!DE_i) y = cl(longint'(m_act[9+ch]));
      else begin
        acc = longint'(m_act[9+ch]) * 16384 + 8192;
        for (int k = 0; k < 3; k++) acc += longint'(m_act[ch*3+k]) * px[k];
        y = cl(acc >>> 14);
      end
      if (ch == 0) e.r = y; else if (ch == 1) e.g = y; else e.b = y;
    end
    return e;
  endfunction

  task automatic model_step();
    exp_t e;
    bit fs;
    if (reset) begin
      model_reset();
      return;
    end
    fs = VSYNC_i && !m_vs;
    m_vs = VSYNC_i;
    if (fs) begin
      m_act = m_sh; m_en = enable; m_pend = 0;
      dc_left = 5;  // pixels already in flight may see mixed old/new settings
    end
    e = expect_now();
    if (coeff_we && coeff_addr < 12) begin
      if (coeff_addr < 9) m_sh[coeff_addr] = $signed(coeff_wdata);
      else                m_sh[coeff_addr] = $signed(coeff_wdata[10:0]);
      m_pend = 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic model_check();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("HSYNC_o", HSYNC_o, e.hs);
      chk("VSYNC_o", VSYNC_o, e.vs);
      chk("DE_o", DE_o, e.de);
      if (dc_left > 0) dc_left--;
      else begin
        chk("R_o", R_o, e.r);
        chk("G_o", G_o, e.g);
        chk("B_o", B_o, e.b);
      end
      chk("commit_pending_o", commit_pending_o, m_pend);
    end
  endtask

  task automatic cycle();
    @(posedge PCLK_i);
    model_step();
    #1;
    model_check();
  endtask

  task automatic wr(input int addr, input int val);
    coeff_we = 1'b1; coeff_addr = 4'(addr); coeff_wdata = 18'(val);
    cycle();
    coeff_we = 1'b0;
  endtask

  task automatic frame();
    DE_i = 1'b0; VSYNC_i = 1'b1;
    repeat (3) cycle();
    VSYNC_i = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic check_pixel(input int r, input int g, input int b,
                             input int er, input int eg, input int eb, input string nm);
    R_i = 8'(r); G_i = 8'(g); B_i = 8'(b); DE_i = 1'b1; HSYNC_i = 1'b1;
    cycle();
    R_i = '0; G_i = '0; B_i = '0; DE_i = 1'b0; HSYNC_i = 1'b0;
    repeat (4) cycle();
    chk({nm, "_de_early"}, DE_o, 0);
    cycle();
    chk({nm, "_de"}, DE_o, 1);
    chk({nm, "_hs"}, HSYNC_o, 1);
    chk({nm, "_r"}, R_o, er);
    chk({nm, "_g"}, G_o, eg);
    chk({nm, "_b"}, B_o, eb);
  endtask

  initial begin
    vec_t tbl[6];
    int bt[12];
    int v;
    tbl[0] = '{255, 255, 255, 255, 128, 128};
    tbl[1] = '{0,   0,   0,   0,   128, 128};
    tbl[2] = '{255, 0,   0,   54,  99,  255};
    tbl[3] = '{0,   255, 0,   182, 30,  12};
    tbl[4] = '{0,   0,   255, 18,  255, 116};
    tbl[5] = '{128, 128, 128, 128, 128, 128};
    bt = '{3483, 11718, 1183, -1877, -6315, 8192, 8192, -7441, -751, 0, 128, 128};

    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    chk("rst_R_o", R_o, 0);
    chk("rst_DE_o", DE_o, 0);
    chk("rst_pending", commit_pending_o, 0);

    enable = 1'b1;
    frame();
    check_pixel(10, 20, 30, 10, 20, 30, "identity");

    for (int i = 0; i < 12; i++) wr(i, bt[i]);
    chk("pending_after_write", commit_pending_o, 1);
    check_pixel(255, 255, 255, 255, 255, 255, "old_matrix");
    chk("pending_held", commit_pending_o, 1);
    frame();
    chk("pending_cleared", commit_pending_o, 0);
    wr(12, 77);
    wr(15, 5);
    chk("pending_ignored_addr", commit_pending_o, 0);
    for (int i = 0; i < 6; i++)
      check_pixel(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].er, tbl[i].eg, tbl[i].eb, $sformatf("bt709_%0d", i));

    VSYNC_i = 1'b1; coeff_we = 1'b1; coeff_addr = 4'd0; coeff_wdata = 18'(32768);
    cycle();
    coeff_we = 1'b0;
    chk("pending_fs_write", commit_pending_o, 1);
    repeat (2) cycle();
    VSYNC_i = 1'b0;
    repeat (3) cycle();
    check_pixel(255, 0, 0, 54, 99, 255, "fs_write_shadow_only");
    frame();
    check_pixel(200, 0, 0, 255, 105, 228, "clamp_high");
    wr(0, -16384);
    frame();
    check_pixel(50, 0, 0, 0, 122, 153, "clamp_low");

    enable = 1'b0;
    check_pixel(200, 0, 0, 0, 105, 228, "en_off_midframe");
    frame();
    check_pixel(200, 0, 0, 200, 0, 0, "bypass");
    enable = 1'b1;
    check_pixel(12, 34, 56, 12, 34, 56, "en_on_midframe");

    wr(3, 1000);
    chk("pending_before_reset", commit_pending_o, 1);
    R_i = 8'd9; DE_i = 1'b1;
    reset = 1'b1;
    cycle();
    reset = 1'b0; DE_i = 1'b0; R_i = '0;
    chk("midrst_R_o", R_o, 0);
    chk("midrst_G_o", G_o, 0);
    chk("midrst_B_o", B_o, 0);
    chk("midrst_DE_o", DE_o, 0);
    chk("midrst_pending", commit_pending_o, 0);
    frame();
    check_pixel(77, 88, 99, 77, 88, 99, "identity_after_reset");
    R_i = 8'd50; G_i = 8'd60; B_i = 8'd70; DE_i = 1'b0;
    repeat (6) cycle();
    chk("blank_R", R_o, 0);
    chk("blank_G", G_o, 0);
    chk("blank_B", B_o, 0);

    for (int i = 0; i < 600; i++) begin
      R_i = 8'($urandom); G_i = 8'($urandom); B_i = 8'($urandom);
      DE_i = 1'($urandom); HSYNC_i = 1'($urandom);
      VSYNC_i = ((i % 40) < 3);
      enable = ($urandom_range(0, 3) != 0);
      coeff_we = ($urandom_range(0, 7) == 0);
      coeff_addr = 4'($urandom_range(0, 15));
      if (coeff_addr < 9) v = int'($urandom_range(0, 49152)) - 16384;
      else                v = int'($urandom_range(0, 600)) - 200;
      coeff_wdata = 18'(v);
      cycle();
    end
    coeff_we = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
